uart_rx_core: RTL and testbench
===============================

Name: uart_rx_core

Overview:
- Serial receive engine for the UART peripheral. It sits directly upstream of the APB register-interface slave.
- Oversamples the serial line using a programmable bit period and frames 5–8 data bits plus one stop bit.
- Presents received data with data_ready, overrun_error and framing_error status. Consumes data_read, data_size and bit_period from the register block.

Parameters:
- MIN_PERIOD, 4, smallest accepted bit_period; smaller programmed values are clamped up to this.

Ports:
- clk  input  1  system clock; all logic on rising edge.
- n_rst  input  1  asynchronous active-low reset.
- serial_in  input  1  asynchronous serial line; idles high.
- data_size  input  4  data bits per frame; 5..8 valid.
- bit_period  input  14  clocks per serial bit.
- data_read  input  1  one-cycle pulse from register block; acknowledges rx_data.
- rx_data  output  8  last good frame, right-justified, unused upper bits 0.
- data_ready  output  1  unread data present in rx_data.
- overrun_error  output  1  a good frame arrived while data_ready was still set.
- framing_error  output  1  last completed frame had stop bit = 0.

Behaviour:
- Reset values:
  - rx_data=0, data_ready=0, overrun_error=0, framing_error=0.
  - Synchronizer flops=1, FSM=IDLE, counters=0.
- Input synchronization:
  - serial_in passes through a 2-flop synchronizer, then one edge-detect flop.
  - A start edge is prev=1 and cur=0 on the synchronized line. It is detected only in IDLE.
- Configuration latching:
  - On start edge, latch bp = max(bit_period, MIN_PERIOD).
  - On start edge, latch n = data_size clamped to 5..8 (values <5 use 5, >8 use 8).
  - Mid-frame changes on bit_period or data_size have no effect on the current frame.
- FSM states: IDLE, START_CHK, DATA, STOP, LOAD.
  - IDLE -> START_CHK on start edge, at cycle t0. Bit counter is cleared.
  - START_CHK: sample at t0+floor(bp/2).
    - Sampled 1: false start, go to IDLE with no output change.
    - Sampled 0: go to DATA.
  - DATA: sample bit k (k=0..n-1, LSB first) at t0+floor(bp/2)+(k+1)*bp. After bit n-1, go to STOP.
  - STOP: sample at t0+floor(bp/2)+(n+1)*bp, then go to LOAD.
  - LOAD: one cycle. Outputs update at the end of this cycle, so they are visible 1 cycle after the stop sample. Then go to IDLE.
  - A line that is still low in IDLE does not start a frame. A fresh 1->0 edge is required.
- Timing counter: 14-bit, counts clocks within the bit, reloads on each sample point. No wrap is possible because it is bounded by bp-1.
- LOAD with stop=1 (good frame):
  - rx_data <= shifted bits with upper 8-n bits zero.
  - data_ready <= 1.
  - framing_error <= 0.
  - If data_ready=1 and data_read=0 this cycle: overrun_error <= 1. The new data overwrites rx_data.
- LOAD with stop=0 (bad frame):
  - framing_error <= 1.
  - rx_data and data_ready unchanged.
  - overrun_error is not set.
- data_read handling:
  - Outside LOAD: data_read=1 clears data_ready and overrun_error next cycle.
  - data_read coincident with a good LOAD: data_ready stays 1, overrun_error cleared, no overrun flagged.
  - data_read while data_ready=0: no effect.
- framing_error persists until the next good frame's LOAD or reset.
- Reset asserted mid-frame: all state returns to reset values immediately. A partial frame is discarded with no flags.
- Latency from start edge to data_ready high: floor(bp/2)+(n+1)*bp+1 clocks, plus 3 clocks of synchronizer/edge delay from the serial_in pin.

Test Plan:
- bp=10, size=8, send 0xA5 with stop=1 -> data_ready rises at t0+96, rx_data=0xA5, both errors 0. data_read pulse -> data_ready=0 next cycle.
- bp=20, size=5, send bits 1,0,1,1,0 (LSB first) with stop=1 -> rx_data=0x0D, data_ready=1. bit_period changed to 7 mid-frame -> no effect on this frame.
- bp=10, size=8, send 0x3C with stop=0 -> framing_error=1, data_ready=0, rx_data unchanged. Next good frame 0x11 -> framing_error=0, rx_data=0x11.
- bp=10, two good frames 0x55 then 0xAA, no data_read -> overrun_error=1, rx_data=0xAA. data_read pulse -> data_ready=0 and overrun_error=0. A data_read coincident with LOAD -> no overrun.
- bp=10, 3-cycle low glitch on serial_in -> FSM returns to IDLE at t0+5, no output change. bit_period=2 -> bp clamped to 4, 0x96 received correctly.
- n_rst asserted at data bit 4 of a frame -> all outputs 0 immediately. After release, the next frame 0x7E is received correctly.

Source files
------------

// File: rtl/uart_rx_core_if.sv
// Signal bundle between the UART receive engine and the register block.
// The slave modport is the receive core; the master modport is the
// register-block side that drives line, configuration and read strobes.
interface uart_rx_core_if;
    logic        serial_in;
    logic [3:0]  data_size;
    logic [13:0] bit_period;
    logic        data_read;
    logic [7:0]  rx_data;
    logic        data_ready;
    logic        overrun_error;
    logic        framing_error;

    modport slave (
        input  serial_in,
        input  data_size,
        input  bit_period,
        input  data_read,
        output rx_data,
        output data_ready,
        output overrun_error,
        output framing_error
    );

    modport master (
        output serial_in,
        output data_size,
        output bit_period,
        output data_read,
        input  rx_data,
        input  data_ready,
        input  overrun_error,
        input  framing_error
    );
endinterface

// File: rtl/uart_rx_core.sv
// UART receive engine: synchronises the serial line, frames 5..8 data bits
// plus one stop bit at a programmable bit period, and keeps the received
// byte together with ready / overrun / framing status for the register block.
module uart_rx_core #(
    parameter int unsigned MIN_PERIOD = 4
) (
    input  logic          clk,
    input  logic          n_rst,
    uart_rx_core_if.slave bus
);
    localparam logic [13:0] MIN_BP = 14'(MIN_PERIOD);

    typedef enum logic [2:0] {
        ST_IDLE      = 3'd0,
        ST_START_CHK = 3'd1,
        ST_DATA      = 3'd2,
        ST_STOP      = 3'd3,
        ST_LOAD      = 3'd4
    } state_t;

    state_t      r_state;
    state_t      w_state_nxt;
    logic        r_sync1;
    logic        r_sync2;
    logic        r_prev;
    logic [13:0] r_cnt;
    logic [13:0] r_bp;
    logic [3:0]  r_n;
    logic [3:0]  r_bitidx;
    logic [7:0]  r_shift;
    logic        r_stop;
    logic [7:0]  r_rx_data;
    logic        r_data_ready;
    logic        r_overrun;
    logic        r_framing;

    logic        w_start_edge;
    logic        w_start;
    logic        w_sample;
    logic [13:0] w_half;
    logic [13:0] w_bp_clamped;
    logic [3:0]  w_n_clamped;

    // The edge is seen one flop after the synchroniser so a line that is
    // already low when the engine returns to idle never starts a frame.
    assign w_start_edge = r_prev & ~r_sync2;
    assign w_half       = {1'b0, r_bp[13:1]};
    assign w_bp_clamped = (bus.bit_period < MIN_BP) ? MIN_BP : bus.bit_period;
    assign w_n_clamped  = (bus.data_size < 4'd5) ? 4'd5 :
                          ((bus.data_size > 4'd8) ? 4'd8 : bus.data_size);

    // Two-flop synchroniser on the asynchronous line plus the edge-detect flop.
    always_ff @(posedge clk or negedge n_rst) begin
        if (!n_rst) begin
            r_sync1 <= 1'b1;
            r_sync2 <= 1'b1;
            r_prev  <= 1'b1;
        end else begin
            r_sync1 <= bus.serial_in;
            r_sync2 <= r_sync1;
            r_prev  <= r_sync2;
        end
    end

    // FSM state register.
    always_ff @(posedge clk or negedge n_rst) begin
        if (!n_rst) begin
            r_state <= ST_IDLE;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    // Next-state logic and sample-point strobe; the start check samples
    // mid start bit, data and stop bits one full period apart after that.
    always_comb begin
        w_state_nxt = r_state;
        w_sample    = 1'b0;
        w_start     = 1'b0;
        case (r_state)
            ST_IDLE: begin
                if (w_start_edge) begin
                    w_start     = 1'b1;
                    w_state_nxt = ST_START_CHK;
                end else begin
                    w_state_nxt = ST_IDLE;
                end
            end
            ST_START_CHK: begin
                if (r_cnt == (w_half - 14'd1)) begin
                    w_sample    = 1'b1;
                    w_state_nxt = r_sync2 ? ST_IDLE : ST_DATA;
                end else begin
                    w_state_nxt = ST_START_CHK;
                end
            end
            ST_DATA: begin
                if (r_cnt == (r_bp - 14'd1)) begin
                    w_sample    = 1'b1;
                    w_state_nxt = (r_bitidx == (r_n - 4'd1)) ? ST_STOP : ST_DATA;
                end else begin
                    w_state_nxt = ST_DATA;
                end
            end
            ST_STOP: begin
                if (r_cnt == (r_bp - 14'd1)) begin
                    w_sample    = 1'b1;
                    w_state_nxt = ST_LOAD;
                end else begin
                    w_state_nxt = ST_STOP;
                end
            end
            ST_LOAD: begin
                w_state_nxt = ST_IDLE;
            end
            default: begin
                w_state_nxt = ST_IDLE;
            end
        endcase
    end

    // Bit timing counter: counts clocks inside a bit and restarts at each sample point.
    always_ff @(posedge clk or negedge n_rst) begin
        if (!n_rst) begin
            r_cnt <= 14'd0;
        end else begin
            case (r_state)
                ST_START_CHK, ST_DATA, ST_STOP: r_cnt <= w_sample ? 14'd0 : (r_cnt + 14'd1);
                default:                        r_cnt <= 14'd0;
            endcase
        end
    end

    // Frame datapath: configuration latched at the start edge, data bits
    // written LSB first straight into their final positions, stop bit captured.
    always_ff @(posedge clk or negedge n_rst) begin
        if (!n_rst) begin
            r_bp     <= MIN_BP;
            r_n      <= 4'd8;
            r_bitidx <= 4'd0;
            r_shift  <= 8'd0;
            r_stop   <= 1'b0;
        end else if (w_start) begin
            r_bp     <= w_bp_clamped;
            r_n      <= w_n_clamped;
            r_bitidx <= 4'd0;
            r_shift  <= 8'd0;
        end else if ((r_state == ST_DATA) && w_sample) begin
            r_shift[r_bitidx[2:0]] <= r_sync2;
            r_bitidx               <= r_bitidx + 4'd1;
        end else if ((r_state == ST_STOP) && w_sample) begin
            r_stop <= r_sync2;
        end
    end

    // Status and data outputs: a good frame loads data, a bad one only flags
    // framing; a read coincident with a good load acknowledges the old byte.
    always_ff @(posedge clk or negedge n_rst) begin
        if (!n_rst) begin
            r_rx_data    <= 8'd0;
            r_data_ready <= 1'b0;
            r_overrun    <= 1'b0;
            r_framing    <= 1'b0;
        end else if ((r_state == ST_LOAD) && r_stop) begin
            r_rx_data    <= r_shift;
            r_data_ready <= 1'b1;
            r_framing    <= 1'b0;
            if (r_data_ready && !bus.data_read) begin
                r_overrun <= 1'b1;
            end else if (bus.data_read) begin
                r_overrun <= 1'b0;
            end
        end else if (r_state == ST_LOAD) begin
            r_framing <= 1'b1;
            if (bus.data_read) begin
                r_data_ready <= 1'b0;
                r_overrun    <= 1'b0;
            end
        end else if (bus.data_read) begin
            r_data_ready <= 1'b0;
            r_overrun    <= 1'b0;
        end
    end

    assign bus.rx_data       = r_rx_data;
    assign bus.data_ready    = r_data_ready;
    assign bus.overrun_error = r_overrun;
    assign bus.framing_error = r_framing;
endmodule

// File: tb/tb_uart_rx_core.sv
// Directed testbench for uart_rx_core: drives whole serial frames cycle by
// cycle and compares status/data against hand-computed values.
module tb_uart_rx_core;
    logic clk;
    logic n_rst;
    int   checks;
    int   failures;
    int   rise_c;

    uart_rx_core_if u_if();

    uart_rx_core #(.MIN_PERIOD(4)) u_dut (
        .clk   (clk),
        .n_rst (n_rst),
        .bus   (u_if.slave)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Hold the line idle high for k cycles (entered and left on a negedge).
    task automatic idle(input int k);
        for (int i = 0; i < k; i++) begin
            u_if.serial_in = 1'b1;
            @(posedge clk);
            @(negedge clk);
        end
    endtask

    // One data_read pulse, one clock wide.
    task automatic read_pulse();
        u_if.data_read = 1'b1;
        @(posedge clk);
        @(negedge clk);
        u_if.data_read = 1'b0;
    endtask

    // Drive a frame: c indexes the cycle from the start-bit pin edge. Records in
    // rise_c the index after which data_ready was first seen rising. Optional
    // mid-frame bit_period change (mid_bp>=0), data_read pulse at rd_c, and
    // early abort after max_c cycles.
    task automatic drive_frame(input int bpd, input int n, input logic [7:0] data,
                               input logic stop_bit, input int mid_bp,
                               input int rd_c, input int max_c);
        int   total;
        logic prev_rdy;
        total    = (n + 2) * bpd;
        rise_c   = -1;
        prev_rdy = u_if.data_ready;
        for (int c = 0; (c < total + 8) && (c < max_c); c++) begin
            if (c < bpd)                  u_if.serial_in = 1'b0;
            else if (c < (n + 1) * bpd)   u_if.serial_in = data[(c / bpd) - 1];
            else if (c < total)           u_if.serial_in = stop_bit;
            else                          u_if.serial_in = 1'b1;
            u_if.data_read = (c == rd_c);
            if ((mid_bp >= 0) && (c == 2 * bpd)) u_if.bit_period = 14'(mid_bp);
            @(posedge clk);
            @(negedge clk);
            if (!prev_rdy && u_if.data_ready && (rise_c < 0)) rise_c = c;
            prev_rdy = u_if.data_ready;
        end
        u_if.data_read = 1'b0;
        u_if.serial_in = 1'b1;
    endtask

    task automatic test_reset();
        n_rst = 1'b0;
        u_if.serial_in = 1'b1; u_if.data_size = 4'd8; u_if.bit_period = 14'd10; u_if.data_read = 1'b0;
        repeat (3) @(negedge clk);
        checks++; if (u_if.rx_data !== 8'h00) begin failures++; $display("FAIL reset_rx_data got=%h exp=00", u_if.rx_data); end
        checks++; if (u_if.data_ready !== 1'b0) begin failures++; $display("FAIL reset_ready got=%b exp=0", u_if.data_ready); end
        checks++; if (u_if.overrun_error !== 1'b0) begin failures++; $display("FAIL reset_overrun got=%b exp=0", u_if.overrun_error); end
        checks++; if (u_if.framing_error !== 1'b0) begin failures++; $display("FAIL reset_framing got=%b exp=0", u_if.framing_error); end
        n_rst = 1'b1;
        idle(5);
    endtask

    task automatic test_basic();
        drive_frame(10, 8, 8'hA5, 1'b1, -1, -1, 1000);
        checks++; if (rise_c !== 98) begin failures++; $display("FAIL basic_latency got=%0d exp=98", rise_c); end
        checks++; if (u_if.rx_data !== 8'hA5) begin failures++; $display("FAIL basic_rx got=%h exp=a5", u_if.rx_data); end
        checks++; if (u_if.data_ready !== 1'b1) begin failures++; $display("FAIL basic_ready got=%b exp=1", u_if.data_ready); end
        checks++; if (u_if.overrun_error !== 1'b0) begin failures++; $display("FAIL basic_overrun got=%b exp=0", u_if.overrun_error); end
        checks++; if (u_if.framing_error !== 1'b0) begin failures++; $display("FAIL basic_framing got=%b exp=0", u_if.framing_error); end
        read_pulse();
        checks++; if (u_if.data_ready !== 1'b0) begin failures++; $display("FAIL basic_read_clear got=%b exp=0", u_if.data_ready); end
        checks++; if (u_if.rx_data !== 8'hA5) begin failures++; $display("FAIL basic_rx_hold got=%h exp=a5", u_if.rx_data); end
        idle(3);
    endtask

    task automatic test_size5();
        u_if.data_size = 4'd5; u_if.bit_period = 14'd20;
        drive_frame(20, 5, 8'h0D, 1'b1, 7, -1, 1000);
        checks++; if (rise_c !== 133) begin failures++; $display("FAIL size5_latency got=%0d exp=133", rise_c); end
        checks++; if (u_if.rx_data !== 8'h0D) begin failures++; $display("FAIL size5_rx got=%h exp=0d", u_if.rx_data); end
        checks++; if (u_if.data_ready !== 1'b1) begin failures++; $display("FAIL size5_ready got=%b exp=1", u_if.data_ready); end
        u_if.data_size = 4'd8; u_if.bit_period = 14'd10;
        read_pulse();
        idle(3);
    endtask

    task automatic test_framing();
        drive_frame(10, 8, 8'h3C, 1'b0, -1, -1, 1000);
        idle(3);
        checks++; if (u_if.framing_error !== 1'b1) begin failures++; $display("FAIL frm_flag got=%b exp=1", u_if.framing_error); end
        checks++; if (u_if.data_ready !== 1'b0) begin failures++; $display("FAIL frm_ready got=%b exp=0", u_if.data_ready); end
        checks++; if (u_if.rx_data !== 8'h0D) begin failures++; $display("FAIL frm_rx_hold got=%h exp=0d", u_if.rx_data); end
        checks++; if (u_if.overrun_error !== 1'b0) begin failures++; $display("FAIL frm_overrun got=%b exp=0", u_if.overrun_error); end
        drive_frame(10, 8, 8'h11, 1'b1, -1, -1, 1000);
        checks++; if (u_if.framing_error !== 1'b0) begin failures++; $display("FAIL frm_clear got=%b exp=0", u_if.framing_error); end
        checks++; if (u_if.rx_data !== 8'h11) begin failures++; $display("FAIL frm_next_rx got=%h exp=11", u_if.rx_data); end
        checks++; if (u_if.data_ready !== 1'b1) begin failures++; $display("FAIL frm_next_ready got=%b exp=1", u_if.data_ready); end
        read_pulse();
        idle(3);
    endtask

    task automatic test_overrun();
        drive_frame(10, 8, 8'h55, 1'b1, -1, -1, 1000);
        checks++; if (u_if.overrun_error !== 1'b0) begin failures++; $display("FAIL ovr_first got=%b exp=0", u_if.overrun_error); end
        idle(3);
        drive_frame(10, 8, 8'hAA, 1'b1, -1, -1, 1000);
        checks++; if (u_if.overrun_error !== 1'b1) begin failures++; $display("FAIL ovr_flag got=%b exp=1", u_if.overrun_error); end
        checks++; if (u_if.rx_data !== 8'hAA) begin failures++; $display("FAIL ovr_rx got=%h exp=aa", u_if.rx_data); end
        read_pulse();
        checks++; if (u_if.data_ready !== 1'b0) begin failures++; $display("FAIL ovr_read_ready got=%b exp=0", u_if.data_ready); end
        checks++; if (u_if.overrun_error !== 1'b0) begin failures++; $display("FAIL ovr_read_clear got=%b exp=0", u_if.overrun_error); end
        idle(3);
        drive_frame(10, 8, 8'h0F, 1'b1, -1, -1, 1000);
        idle(3);
        drive_frame(10, 8, 8'hF0, 1'b1, -1, 98, 1000);
        checks++; if (u_if.data_ready !== 1'b1) begin failures++; $display("FAIL coinc_ready got=%b exp=1", u_if.data_ready); end
        checks++; if (u_if.overrun_error !== 1'b0) begin failures++; $display("FAIL coinc_overrun got=%b exp=0", u_if.overrun_error); end
        checks++; if (u_if.rx_data !== 8'hF0) begin failures++; $display("FAIL coinc_rx got=%h exp=f0", u_if.rx_data); end
        read_pulse();
        idle(3);
    endtask

    task automatic test_glitch_clamp();
        for (int i = 0; i < 8; i++) begin
            u_if.serial_in = (i < 3) ? 1'b0 : 1'b1;
            @(posedge clk);
            @(negedge clk);
        end
        checks++; if (u_if.data_ready !== 1'b0) begin failures++; $display("FAIL glitch_ready got=%b exp=0", u_if.data_ready); end
        checks++; if (u_if.framing_error !== 1'b0) begin failures++; $display("FAIL glitch_framing got=%b exp=0", u_if.framing_error); end
        drive_frame(10, 8, 8'hC3, 1'b1, -1, -1, 1000);
        checks++; if (rise_c !== 98) begin failures++; $display("FAIL glitch_next_latency got=%0d exp=98", rise_c); end
        checks++; if (u_if.rx_data !== 8'hC3) begin failures++; $display("FAIL glitch_next_rx got=%h exp=c3", u_if.rx_data); end
        read_pulse();
        idle(3);
        u_if.bit_period = 14'd2;
        drive_frame(4, 8, 8'h96, 1'b1, -1, -1, 1000);
        checks++; if (rise_c !== 41) begin failures++; $display("FAIL clamp_latency got=%0d exp=41", rise_c); end
        checks++; if (u_if.rx_data !== 8'h96) begin failures++; $display("FAIL clamp_rx got=%h exp=96", u_if.rx_data); end
        u_if.bit_period = 14'd10;
        idle(3);
    endtask

    task automatic test_reset_mid();
        drive_frame(10, 8, 8'h44, 1'b0, -1, -1, 1000);
        idle(3);
        checks++; if (u_if.framing_error !== 1'b1) begin failures++; $display("FAIL rstmid_pre_framing got=%b exp=1", u_if.framing_error); end
        drive_frame(10, 8, 8'hFF, 1'b1, -1, -1, 55);
        n_rst = 1'b0;
        #1;
        checks++; if (u_if.rx_data !== 8'h00) begin failures++; $display("FAIL rstmid_rx got=%h exp=00", u_if.rx_data); end
        checks++; if (u_if.data_ready !== 1'b0) begin failures++; $display("FAIL rstmid_ready got=%b exp=0", u_if.data_ready); end
        checks++; if (u_if.framing_error !== 1'b0) begin failures++; $display("FAIL rstmid_framing got=%b exp=0", u_if.framing_error); end
        checks++; if (u_if.overrun_error !== 1'b0) begin failures++; $display("FAIL rstmid_overrun got=%b exp=0", u_if.overrun_error); end
        repeat (3) @(negedge clk);
        n_rst = 1'b1;
        idle(10);
        checks++; if (u_if.data_ready !== 1'b0) begin failures++; $display("FAIL rstmid_no_flag got=%b exp=0", u_if.data_ready); end
        u_if.data_size = 4'd12;
        drive_frame(10, 8, 8'h7E, 1'b1, -1, -1, 1000);
        checks++; if (rise_c !== 98) begin failures++; $display("FAIL rstmid_latency got=%0d exp=98", rise_c); end
        checks++; if (u_if.rx_data !== 8'h7E) begin failures++; $display("FAIL rstmid_rx_next got=%h exp=7e", u_if.rx_data); end
        checks++; if (u_if.framing_error !== 1'b0) begin failures++; $display("FAIL rstmid_framing_next got=%b exp=0", u_if.framing_error); end
        u_if.data_size = 4'd8;
    endtask

    initial begin
        checks   = 0;
        failures = 0;
        rise_c   = -1;
        test_reset();
        test_basic();
        test_size5();
        test_framing();
        test_overrun();
        test_glitch_clamp();
        test_reset_mid();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
